// File: rtl/cache_refill_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl_pkg
// Shared cache geometry, block types, controller state encoding and helpers
// used by the refill controller, its bus interface and the victim selector.
// No ports (package).
// -----------------------------------------------------------------------------
package cache_refill_ctrl_pkg;

   localparam int NumSets       = 4;
   localparam int Associativity = 2;
   localparam int TagWidth      = 8;
   localparam int DataWidth     = 32;
   localparam int SetWidth      = (NumSets > 1) ? $clog2(NumSets) : 1;
   localparam int WayWidth      = (Associativity > 1) ? $clog2(Associativity) : 1;

   typedef struct packed {
      logic                valid;
      logic [TagWidth-1:0] tag;
   } block_info_t;

   typedef logic [DataWidth-1:0]         block_data_t;
   typedef block_info_t [Associativity-1:0] info_line_t;
   typedef logic [TagWidth+SetWidth-1:0] mem_addr_t;
   typedef logic [SetWidth-1:0]          set_t;
   typedef logic [TagWidth-1:0]          tag_t;
   typedef logic [WayWidth-1:0]          way_t;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_LOOKUP,
      ST_MEM_REQ,
      ST_MEM_WAIT,
      ST_REFILL,
      ST_RESP
   } refill_state_e;

   // Round-robin successor, wrapping at the configured associativity
   // (which need not be a power of two).
   function automatic way_t next_rr(input way_t p);
      if (int'(p) >= Associativity - 1) return '0;
      else                              return p + way_t'(1);
   endfunction

endpackage

// File: rtl/cache_refill_ctrl_if.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl_if
// Bundles every non-clock/reset signal of the refill controller: request and
// response handshakes, cache read/write ports, memory port and statistics.
//   master : controller side (drives req_ready, resp_*, cache_*_o, mem_req_*, counts)
//   slave  : environment side (requester, cache and memory)
// Parameter CountWidth: width of the hit/miss counters.
// -----------------------------------------------------------------------------
interface cache_refill_ctrl_if #(
   parameter int CountWidth = 32
);
   import cache_refill_ctrl_pkg::*;

   logic                  req_valid_i;
   logic                  req_ready_o;
   set_t                  req_set_i;
   tag_t                  req_tag_i;

   logic                  resp_valid_o;
   logic                  resp_ready_i;
   block_data_t           resp_data_o;
   logic                  resp_miss_o;

   set_t                  cache_read_set_o;
   tag_t                  cache_read_tag_o;
   logic                  cache_read_hit_i;
   block_data_t           cache_read_data_i;

   logic                  cache_write_en_o;
   set_t                  cache_write_set_o;
   info_line_t            cache_write_info_o;
   way_t                  cache_write_data_way_o;
   block_data_t           cache_write_data_o;

   logic                  mem_req_valid_o;
   logic                  mem_req_ready_i;
   mem_addr_t             mem_req_addr_o;
   logic                  mem_resp_valid_i;
   block_data_t           mem_resp_data_i;

   logic [CountWidth-1:0] hit_count_o;
   logic [CountWidth-1:0] miss_count_o;

   modport master (
      input  req_valid_i, req_set_i, req_tag_i, resp_ready_i,
             cache_read_hit_i, cache_read_data_i,
             mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
      output req_ready_o, resp_valid_o, resp_data_o, resp_miss_o,
             cache_read_set_o, cache_read_tag_o,
             cache_write_en_o, cache_write_set_o, cache_write_info_o,
             cache_write_data_way_o, cache_write_data_o,
             mem_req_valid_o, mem_req_addr_o, hit_count_o, miss_count_o
   );

   modport slave (
      output req_valid_i, req_set_i, req_tag_i, resp_ready_i,
             cache_read_hit_i, cache_read_data_i,
             mem_req_ready_i, mem_resp_valid_i, mem_resp_data_i,
      input  req_ready_o, resp_valid_o, resp_data_o, resp_miss_o,
             cache_read_set_o, cache_read_tag_o,
             cache_write_en_o, cache_write_set_o, cache_write_info_o,
             cache_write_data_way_o, cache_write_data_o,
             mem_req_valid_o, mem_req_addr_o, hit_count_o, miss_count_o
   );

endinterface

// File: rtl/cache_refill_ctrl_victim_select.sv
// -----------------------------------------------------------------------------
// victim_select
// Combinational replacement choice for one set.
//   i_info   : current info line of the set
//   i_rr_ptr : round-robin pointer of the set
//   o_way    : way to receive the refill
//   o_evict  : 1 when a valid way is being replaced (pointer must advance)
// -----------------------------------------------------------------------------
module victim_select
   import cache_refill_ctrl_pkg::*;
(
   input  info_line_t i_info,
   input  way_t       i_rr_ptr,
   output way_t       o_way,
   output logic       o_evict
);

   always_comb begin
      o_way   = (Associativity == 1) ? '0 : i_rr_ptr;
      o_evict = 1'b1;
      // Scan from the top so the lowest-index invalid way is the one kept.
      for (int w = Associativity - 1; w >= 0; w--) begin
         if (!i_info[w].valid) begin
            o_way   = way_t'(w);
            o_evict = 1'b0;
         end
      end
   end

endmodule

// File: rtl/cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// cache_refill_ctrl
// Sits in front of the cache: serves lookups, refills misses from memory,
// picks victims, and owns the only write path into the cache. Keeps a shadow
// copy of every set's info line and sweeps the cache invalid after reset.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   bus    : request/response, cache read/write, memory and statistics
// Parameter CountWidth: width of the saturating hit/miss counters.
// -----------------------------------------------------------------------------
module cache_refill_ctrl
   import cache_refill_ctrl_pkg::*;
#(
   parameter int CountWidth = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   cache_refill_ctrl_if.master  bus
);

   refill_state_e         r_state, w_state_nxt;
   set_t                  r_init_set;
   set_t                  r_set;
   tag_t                  r_tag;
   block_data_t           r_data;
   logic                  r_miss;
   logic [CountWidth-1:0] r_hit_cnt, r_miss_cnt;
   info_line_t            r_info [NumSets];
   way_t                  r_rr   [NumSets];

   info_line_t            w_cur_line, w_new_line;
   way_t                  w_victim_way;
   logic                  w_evict;

   function automatic logic [CountWidth-1:0] sat_inc(input logic [CountWidth-1:0] v);
      return (&v) ? v : v + CountWidth'(1);
   endfunction

   assign w_cur_line = r_info[r_set];

   victim_select u_victim_select (
      .i_info   (w_cur_line),
      .i_rr_ptr (r_rr[r_set]),
      .o_way    (w_victim_way),
      .o_evict  (w_evict)
   );

   always_comb begin
      w_new_line                     = w_cur_line;
      w_new_line[w_victim_way].valid = 1'b1;
      w_new_line[w_victim_way].tag   = r_tag;
   end

   assign bus.resp_data_o      = r_data;
   assign bus.resp_miss_o      = r_miss;
   assign bus.cache_read_set_o = r_set;
   assign bus.cache_read_tag_o = r_tag;
   assign bus.mem_req_addr_o   = {r_tag, r_set};
   assign bus.hit_count_o      = r_hit_cnt;
   assign bus.miss_count_o     = r_miss_cnt;

   always_comb begin
      w_state_nxt                = r_state;
      bus.req_ready_o            = 1'b0;
      bus.resp_valid_o           = 1'b0;
      bus.mem_req_valid_o        = 1'b0;
      bus.cache_write_en_o       = 1'b0;
      bus.cache_write_set_o      = '0;
      bus.cache_write_info_o     = '0;
      bus.cache_write_data_way_o = '0;
      bus.cache_write_data_o     = '0;
      case (r_state)
         ST_INIT: begin
            // Gated by reset so the strobe is low while reset is held.
            bus.cache_write_en_o  = rst_ni;
            bus.cache_write_set_o = r_init_set;
            if (int'(r_init_set) == NumSets - 1) w_state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            bus.req_ready_o = 1'b1;
            if (bus.req_valid_i) w_state_nxt = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            w_state_nxt = bus.cache_read_hit_i ? ST_RESP : ST_MEM_REQ;
         end
         ST_MEM_REQ: begin
            bus.mem_req_valid_o = 1'b1;
            if (bus.mem_req_ready_i) w_state_nxt = ST_MEM_WAIT;
         end
         ST_MEM_WAIT: begin
            if (bus.mem_resp_valid_i) w_state_nxt = ST_REFILL;
         end
         ST_REFILL: begin
            bus.cache_write_en_o       = 1'b1;
            bus.cache_write_set_o      = r_set;
            bus.cache_write_info_o     = w_new_line;
            bus.cache_write_data_way_o = w_victim_way;
            bus.cache_write_data_o     = r_data;
            w_state_nxt                = ST_RESP;
         end
         ST_RESP: begin
            bus.resp_valid_o = 1'b1;
            if (bus.resp_ready_i) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ST_INIT;
         r_init_set <= '0;
         r_set      <= '0;
         r_tag      <= '0;
         r_data     <= '0;
         r_miss     <= 1'b0;
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
         for (int s = 0; s < NumSets; s++) begin
            r_info[s] <= '0;
            r_rr[s]   <= '0;
         end
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            ST_INIT: begin
               if (int'(r_init_set) != NumSets - 1) r_init_set <= r_init_set + set_t'(1);
            end
            ST_IDLE: begin
               if (bus.req_valid_i) begin
                  r_set <= bus.req_set_i;
                  r_tag <= bus.req_tag_i;
               end
            end
            ST_LOOKUP: begin
               if (bus.cache_read_hit_i) begin
                  r_data    <= bus.cache_read_data_i;
                  r_miss    <= 1'b0;
                  r_hit_cnt <= sat_inc(r_hit_cnt);
               end else begin
                  r_miss_cnt <= sat_inc(r_miss_cnt);
               end
            end
            ST_MEM_WAIT: begin
               if (bus.mem_resp_valid_i) r_data <= bus.mem_resp_data_i;
            end
            ST_REFILL: begin
               r_info[r_set] <= w_new_line;
               if (w_evict) r_rr[r_set] <= next_rr(r_rr[r_set]);
               r_miss <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_refill_ctrl
// Self-checking bench: a behavioural cache array answers the read port from
// whatever the controller wrote; a reference model predicts hits, victims,
// info lines, response data and counters from the replacement rules.
// -----------------------------------------------------------------------------
module tb_cache_refill_ctrl;
   import cache_refill_ctrl_pkg::*;

   localparam int CW    = 4;
   localparam int CMAXI = (1 << CW) - 1;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cache_refill_ctrl_if #(.CountWidth(CW)) bus();

   cache_refill_ctrl #(.CountWidth(CW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- cache array (environment) ----------------
   info_line_t  c_info [NumSets];
   block_data_t c_data [NumSets][Associativity];

   always @(posedge clk) begin
      if (bus.cache_write_en_o) begin
         c_info[bus.cache_write_set_o] <= bus.cache_write_info_o;
         c_data[bus.cache_write_set_o][bus.cache_write_data_way_o] <= bus.cache_write_data_o;
      end
   end

   always_comb begin
      bus.cache_read_hit_i  = 1'b0;
      bus.cache_read_data_i = '0;
      for (int w = 0; w < Associativity; w++) begin
         if (c_info[bus.cache_read_set_o][w].valid &&
             c_info[bus.cache_read_set_o][w].tag == bus.cache_read_tag_o) begin
            bus.cache_read_hit_i  = 1'b1;
            bus.cache_read_data_i = c_data[bus.cache_read_set_o][w];
         end
      end
   end

   // ---------------- reference model ----------------
   bit          m_valid [NumSets][Associativity];
   int          m_tag   [NumSets][Associativity];
   block_data_t m_data  [NumSets][Associativity];
   int          m_rr    [NumSets];
   int          m_hits, m_misses;

   bit          m_chk;
   bit          m_wr_ok;
   set_t        m_wr_set;
   info_line_t  m_wr_info;
   way_t        m_wr_way;
   block_data_t m_wr_data;
   int          m_wr_seen = 0;
   bit          m_mem_ok;
   mem_addr_t   m_mem_addr;
   block_data_t m_rsp_data;
   bit          m_rsp_miss;

   function automatic int sat(input int v);
      return (v >= CMAXI) ? CMAXI : v + 1;
   endfunction

   task automatic model_reset();
      for (int s = 0; s < NumSets; s++) begin
         m_rr[s] = 0;
         for (int w = 0; w < Associativity; w++) begin
            m_valid[s][w] = 0; m_tag[s][w] = 0; m_data[s][w] = '0;
         end
      end
      m_hits = 0; m_misses = 0; m_wr_ok = 0; m_mem_ok = 0;
      m_rsp_data = '0; m_rsp_miss = 0;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (m_chk) begin
         if (bus.cache_write_en_o) begin
            m_wr_seen = m_wr_seen + 1;
            check("wr_allowed", m_wr_ok, 1);
            check("wr_set",  bus.cache_write_set_o, m_wr_set);
            check("wr_info", bus.cache_write_info_o, m_wr_info);
            check("wr_way",  bus.cache_write_data_way_o, m_wr_way);
            check("wr_data", bus.cache_write_data_o, m_wr_data);
         end
         if (bus.mem_req_valid_o) begin
            check("mem_allowed", m_mem_ok, 1);
            check("mem_addr", bus.mem_req_addr_o, m_mem_addr);
         end
         if (bus.resp_valid_o) begin
            check("resp_data", bus.resp_data_o, m_rsp_data);
            check("resp_miss", bus.resp_miss_o, m_rsp_miss);
            check("hit_count", bus.hit_count_o, m_hits);
            check("miss_count", bus.miss_count_o, m_misses);
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic reset_init(input bit inject_late);
      m_chk = 0;
      rst_n = 1'b0;
      bus.req_valid_i = 0; bus.resp_ready_i = 0; bus.mem_req_ready_i = 0;
      bus.mem_resp_valid_i = 0; bus.mem_resp_data_i = '0;
      bus.req_set_i = '0; bus.req_tag_i = '0;
      model_reset();
      @(negedge clk);
      check("rst_we",    bus.cache_write_en_o, 0);
      check("rst_ready", bus.req_ready_o, 0);
      check("rst_resp",  bus.resp_valid_o, 0);
      check("rst_mem",   bus.mem_req_valid_o, 0);
      check("rst_hits",  bus.hit_count_o, 0);
      check("rst_miss",  bus.miss_count_o, 0);
      check("rst_data",  bus.resp_data_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int i = 0; i < NumSets; i++) begin
         @(negedge clk);
         check("init_we",    bus.cache_write_en_o, 1);
         check("init_set",   bus.cache_write_set_o, i);
         check("init_info",  bus.cache_write_info_o, 0);
         check("init_way",   bus.cache_write_data_way_o, 0);
         check("init_data",  bus.cache_write_data_o, 0);
         check("init_ready", bus.req_ready_o, 0);
         if (inject_late && i == 1) begin
            bus.mem_resp_valid_i = 1'b1;
            bus.mem_resp_data_i  = $urandom;
         end else begin
            bus.mem_resp_valid_i = 1'b0;
         end
      end
      @(negedge clk);
      bus.mem_resp_valid_i = 1'b0;
      check("init_done_ready", bus.req_ready_o, 1);
      check("init_done_we",    bus.cache_write_en_o, 0);
      m_chk = 1;
   endtask

   task automatic txn(input int s, input int t, input logic [31:0] md, input int rdly,
                      input int pin_hit, input int pin_way, input bit abort);
      int hw, vw, n, wr0;
      bit hit;
      info_line_t line;
      hw = -1;
      for (int w = 0; w < Associativity; w++)
         if (m_valid[s][w] && m_tag[s][w] == t) hw = w;
      hit = (hw >= 0);
      if (pin_hit >= 0) check("model_hit", hit, pin_hit);
      if (hit) begin
         m_hits     = sat(m_hits);
         m_rsp_data = m_data[s][hw];
         m_rsp_miss = 0;
      end else begin
         m_misses = sat(m_misses);
         vw = -1;
         for (int w = 0; w < Associativity; w++)
            if (vw < 0 && !m_valid[s][w]) vw = w;
         if (vw < 0) begin
            vw      = m_rr[s];
            m_rr[s] = (m_rr[s] + 1) % Associativity;
         end
         if (pin_way >= 0) check("model_way", vw, pin_way);
         m_valid[s][vw] = 1; m_tag[s][vw] = t; m_data[s][vw] = md;
         for (int w = 0; w < Associativity; w++) begin
            line[w].valid = m_valid[s][w];
            line[w].tag   = tag_t'(m_tag[s][w]);
         end
         m_wr_set   = set_t'(s);
         m_wr_info  = line;
         m_wr_way   = way_t'(vw);
         m_wr_data  = md;
         m_mem_addr = {tag_t'(t), set_t'(s)};
         m_rsp_data = md;
         m_rsp_miss = 1;
      end

      @(posedge clk); #1;
      bus.req_valid_i = 1'b1; bus.req_set_i = set_t'(s); bus.req_tag_i = tag_t'(t);
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.req_ready_o && n < 20);
      check("req_accept", bus.req_ready_o, 1);
      if (!bus.req_ready_o) begin bus.req_valid_i = 1'b0; return; end
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0; bus.req_set_i = set_t'($urandom); bus.req_tag_i = tag_t'($urandom);
      if (!hit) m_mem_ok = 1;
      @(negedge clk);
      check("lookup_set", bus.cache_read_set_o, s);
      check("lookup_tag", bus.cache_read_tag_o, t);
      check("lookup_no_resp", bus.resp_valid_o, 0);
      if (!hit) begin
         @(negedge clk);
         check("mem_req_lat", bus.mem_req_valid_o, 1);
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check("mem_req_hold", bus.mem_req_valid_o, 1);
         end
         bus.mem_req_ready_i = 1'b1;
         @(posedge clk); #1;
         bus.mem_req_ready_i = 1'b0; m_mem_ok = 0;
         @(negedge clk);
         check("mem_req_drop", bus.mem_req_valid_o, 0);
         if (abort) return;
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            check("mem_wait_quiet", bus.cache_write_en_o | bus.resp_valid_o, 0);
         end
         wr0 = m_wr_seen; m_wr_ok = 1;
         bus.mem_resp_valid_i = 1'b1; bus.mem_resp_data_i = md;
         @(posedge clk); #1;
         bus.mem_resp_valid_i = 1'b0; bus.mem_resp_data_i = $urandom;
         @(negedge clk);
         check("refill_we", bus.cache_write_en_o, 1);
         @(posedge clk); #1;
         m_wr_ok = 0;
         @(negedge clk);
         check("refill_count", m_wr_seen - wr0, 1);
      end else begin
         @(negedge clk);
      end
      check("resp_latency", bus.resp_valid_o, 1);
      for (int i = 0; i < rdly; i++) begin
         check("busy_no_ready", bus.req_ready_o, 0);
         @(negedge clk);
         check("resp_hold", bus.resp_valid_o, 1);
      end
      bus.resp_ready_i = 1'b1;
      @(posedge clk); #1;
      bus.resp_ready_i = 1'b0;
      @(negedge clk);
      check("resp_done", bus.resp_valid_o, 0);
      check("back_idle", bus.req_ready_o, 1);
   endtask

   initial begin
      reset_init(0);

      txn(1, 'h12, 32'hDEADBEEF, 0, 0, 0, 0);
      check("lit_miss_addr", bus.mem_req_addr_o, 10'h049);
      check("lit_miss_data", bus.resp_data_o, 32'hDEADBEEF);
      check("lit_miss_flag", bus.resp_miss_o, 1);
      check("lit_miss_cnt",  bus.miss_count_o, 1);

      txn(1, 'h12, $urandom, 0, 1, -1, 0);
      check("lit_hit_data", bus.resp_data_o, 32'hDEADBEEF);
      check("lit_hit_flag", bus.resp_miss_o, 0);
      check("lit_hit_cnt",  bus.hit_count_o, 1);

      txn(2, 'hA0, $urandom, 1, 0, 0, 0);
      txn(2, 'hA1, $urandom, 0, 0, 1, 0);
      txn(2, 'hA2, $urandom, 0, 0, 0, 0);
      txn(2, 'hA3, $urandom, 0, 0, 1, 0);
      txn(2, 'hA2, $urandom, 5, 1, -1, 0);
      txn(2, 'hA0, $urandom, 0, 0, 0, 0);

      txn(3, 'h55, $urandom, 0, 0, -1, 1);
      reset_init(1);
      txn(3, 'h55, $urandom, 0, 0, 0, 0);
      txn(1, 'h12, $urandom, 2, 0, 0, 0);

      for (int k = 0; k < 60; k++)
         txn($urandom_range(0, NumSets - 1), 'hC0 + $urandom_range(0, 2),
             $urandom, $urandom_range(0, 3), -1, -1, 0);

      for (int k = 0; k < 17; k++) txn(0, 'h77, $urandom, 0, -1, -1, 0);
      check("lit_hit_sat", bus.hit_count_o, 4'hF);

      for (int k = 0; k < 18; k++) txn(0, 'h10 + (k % 3), $urandom, 0, 0, -1, 0);
      check("lit_miss_sat", bus.miss_count_o, 4'hF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule
